// File: rtl/wmst_out_fm_burst_writer.sv
// Output-feature-map store engine: packs DW-bit FIFO words into XDW-bit beats and writes strided rows as bursts.
// Latency: accept -> first pop 1 cycle, -> first wmst_go 3 cycles; backpressure: pops stall while a held beat sees buffer_full.
// Optional feature macro WMST_STALL_CNT_EN adds the stall_cnt[31:0] output.
module wmst_out_fm_burst_writer #(
  parameter int DW   = 32,
  parameter int XDW  = 128,
  parameter int XAW  = 32,
  parameter int CW   = 16,
  parameter int BLEN = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [XAW-1:0] cmd_base,
  input  logic [CW-1:0]  cmd_row_len,
  input  logic [CW-1:0]  cmd_row_num,
  input  logic [XAW-1:0] cmd_row_stride,
  input  logic [DW-1:0]  fifo_data,
  input  logic           fifo_empty,
  output logic           fifo_pop,
  output logic           wmst_fixed_location,
  output logic [XAW-1:0] wmst_write_base,
  output logic [XAW-1:0] wmst_write_length,
  output logic           wmst_go,
  input  logic           wmst_done,
  output logic [XDW-1:0] wmst_user_write_data,
  output logic           wmst_user_write_buffer,
  input  logic           wmst_user_buffer_full,
  output logic           busy,
  output logic           store_done
`ifdef WMST_STALL_CNT_EN
  ,
  output logic [31:0]    stall_cnt
`endif
);
  localparam int NW = XDW / DW;
  localparam int LW = (NW > 1) ? $clog2(NW) : 1;
  localparam int TW = 2 * CW;
  localparam int BW = CW + 1;
  localparam int BB = XDW / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_FIN
  } state_t;

  state_t state, state_n;

  logic [XAW-1:0] row_base, stride, addr;
  logic [CW-1:0]  row_len, rows_left, col;
  logic [BW-1:0]  row_beats, beats_left, burst, burst_n;
  logic [TW-1:0]  words_left;
  logic [XDW-1:0] beat, beat_n;
  logic [LW-1:0]  lane, lane_n;
  logic           beat_vld, beat_vld_n;
  logic           accept, row_load, go_set, burst_adv;
  logic           pop, wr, last_word, tile_drained;

  assign accept       = cmd_valid & cmd_ready;
  assign busy         = (state != S_IDLE);
  assign pop          = busy & ~fifo_empty & (words_left != '0) & ~(beat_vld & wmst_user_buffer_full);
  assign wr           = beat_vld & ~wmst_user_buffer_full;
  assign last_word    = (col == row_len - CW'(1));
  assign tile_drained = (words_left == '0) && !beat_vld;
  assign burst_n      = (beats_left > BW'(BLEN)) ? BW'(BLEN) : beats_left;

  assign fifo_pop               = pop;
  assign wmst_fixed_location    = 1'b0;
  assign wmst_user_write_data   = beat;
  assign wmst_user_write_buffer = wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    cmd_ready  = 1'b0;
    row_load   = 1'b0;
    go_set     = 1'b0;
    burst_adv  = 1'b0;
    store_done = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = S_ROW;
      end
      S_ROW: begin
        if (row_len == '0 || rows_left == '0) begin
          state_n = S_FIN;
        end else begin
          row_load = 1'b1;
          state_n  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wmst_done) begin
          go_set  = 1'b1;
          state_n = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!wmst_done) state_n = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (wmst_done) begin
          burst_adv = 1'b1;
          // rows_left was already decremented when this row was loaded
          if (beats_left != burst)  state_n = S_ISSUE;
          else if (rows_left != '0) state_n = S_ROW;
          else                      state_n = S_FIN;
        end
      end
      S_FIN: begin
        if (tile_drained) begin
          store_done = 1'b1;
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A popped word lands in its lane at the next edge; a completed beat is
  // replaced in the same cycle it is handed to the master.
  always_comb begin
    beat_n     = beat;
    lane_n     = lane;
    beat_vld_n = beat_vld;
    if (wr) begin
      beat_n     = '0;
      lane_n     = '0;
      beat_vld_n = 1'b0;
    end
    if (pop) begin
      for (int i = 0; i < NW; i++) begin
        if (lane_n == LW'(i)) beat_n[i*DW +: DW] = fifo_data;
      end
      if (last_word || lane_n == LW'(NW - 1)) begin
        beat_vld_n = 1'b1;
        lane_n     = '0;
      end else begin
        lane_n = lane_n + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base          <= '0;
      stride            <= '0;
      addr              <= '0;
      row_len           <= '0;
      rows_left         <= '0;
      col               <= '0;
      row_beats         <= '0;
      beats_left        <= '0;
      burst             <= '0;
      words_left        <= '0;
      beat              <= '0;
      lane              <= '0;
      beat_vld          <= 1'b0;
      wmst_go           <= 1'b0;
      wmst_write_base   <= '0;
      wmst_write_length <= '0;
    end else begin
      wmst_go  <= go_set;
      beat     <= beat_n;
      lane     <= lane_n;
      beat_vld <= beat_vld_n;
      if (accept) begin
        row_base   <= cmd_base;
        stride     <= cmd_row_stride;
        row_len    <= cmd_row_len;
        rows_left  <= cmd_row_num;
        row_beats  <= BW'((BW'(cmd_row_len) + BW'(NW - 1)) / BW'(NW));
        words_left <= TW'(cmd_row_len) * TW'(cmd_row_num);
        col        <= '0;
      end else if (pop) begin
        words_left <= words_left - TW'(1);
        col        <= last_word ? '0 : col + CW'(1);
      end
      if (row_load) begin
        addr       <= row_base;
        row_base   <= row_base + stride;
        rows_left  <= rows_left - CW'(1);
        beats_left <= row_beats;
      end
      if (go_set) begin
        wmst_write_base   <= addr;
        wmst_write_length <= XAW'(burst_n) * XAW'(BB);
        burst             <= burst_n;
      end
      if (burst_adv) begin
        addr       <= addr + wmst_write_length;
        beats_left <= beats_left - burst;
      end
    end
  end

`ifdef WMST_STALL_CNT_EN
  logic stall;
  assign stall = busy && ((fifo_empty && words_left != '0) || (wmst_user_buffer_full && beat_vld));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      stall_cnt <= '0;
    else if (accept)                 stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
